// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharer of one divider across NUM_REQ requesters; define DIVARB_TIMEOUT_EN for a RUN watchdog
module div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OP_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*OP_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*OP_WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]          ack,
  output logic [OP_WIDTH-1:0]         res_quotient,
  output logic [OP_WIDTH-1:0]         res_remainder,
  output logic                        res_err,
  output logic                        busy,
  output logic [2:0]                  grant_id,
  output logic                        div_reset,
  output logic                        div_start,
  output logic [OP_WIDTH-1:0]         div_dividend,
  output logic [OP_WIDTH-1:0]         div_divisor,
  input  logic [OP_WIDTH-1:0]         div_quotient,
  input  logic [OP_WIDTH-1:0]         div_remainder,
  input  logic                        div_done
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, ZERO, RESP} state_t;
  state_t state;
  logic [2:0] last, win;
  logic [OP_WIDTH-1:0] win_dvd, win_dvs;
  logic [NUM_REQ-1:0] grant_oh;
  logic tmo;
  assign grant_oh = NUM_REQ'(1) << grant_id;
`ifdef DIVARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  // watchdog counts RUN cycles and is held clear outside RUN
  always_ff @(posedge clk or posedge reset)
    if (reset) tmo_cnt <= '0;
    else tmo_cnt <= (state == RUN) ? tmo_cnt + 1'b1 : '0;
  assign tmo = (state == RUN) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif
  // winner is the lowest requester above last, falling back to the lowest overall (wrap)
  always_comb begin
    win = '0;
    win_dvd = '0;
    win_dvs = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) begin
        win = 3'(i);
        win_dvd = req_dividend[i*OP_WIDTH +: OP_WIDTH];
        win_dvs = req_divisor[i*OP_WIDTH +: OP_WIDTH];
      end
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i] && 3'(i) > last) begin
        win = 3'(i);
        win_dvd = req_dividend[i*OP_WIDTH +: OP_WIDTH];
        win_dvs = req_divisor[i*OP_WIDTH +: OP_WIDTH];
      end
  end
  // sequencer: grant, drive the divider, collect or synthesize the result, pulse ack
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ack <= '0;
      res_quotient <= '0;
      res_remainder <= '0;
      res_err <= 1'b0;
      busy <= 1'b0;
      grant_id <= '0;
      div_reset <= 1'b1;
      div_start <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
      last <= 3'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (|req) begin
          div_dividend <= win_dvd;
          div_divisor <= win_dvs;
          grant_id <= win;
          busy <= 1'b1;
          state <= (win_dvs == '0) ? ZERO : LOAD;
        end
        LOAD: begin
          div_reset <= 1'b0;
          div_start <= 1'b1;
          state <= RUN;
        end
        RUN: if (div_done || tmo) begin
          res_quotient <= div_done ? div_quotient : '1;
          res_remainder <= div_done ? div_remainder : '0;
          res_err <= !div_done;
          div_start <= 1'b0;
          ack <= grant_oh;
          state <= RESP;
        end
        ZERO: begin
          res_quotient <= '1;
          res_remainder <= div_dividend;
          res_err <= 1'b1;
          ack <= grant_oh;
          state <= RESP;
        end
        RESP: begin
          ack <= '0;
          last <= grant_id;
          busy <= 1'b0;
          div_reset <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: vector table, hand sequences and randomized round-robin traffic against a reference model
module tb_div_arbiter;
  logic clk = 0, reset = 1;
  logic [3:0] req = '0, ack;
  logic [127:0] req_dividend = '0, req_divisor = '0;
  logic [31:0] res_quotient, res_remainder, div_dividend, div_divisor;
  logic [31:0] div_quotient = '0, div_remainder = '0;
  logic res_err, busy, div_reset, div_start;
  logic div_done = 0;
  logic hang = 0;
  logic [2:0] grant_id;
  int checks = 0, errors = 0, lat = 2, dcnt = 0, last_m = 3;
  int order[$];
  typedef struct { int id; logic [31:0] a, b, q, r; logic err; } vec_t;
  vec_t vecs[8];

  div_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .ack(ack), .res_quotient(res_quotient), .res_remainder(res_remainder), .res_err(res_err),
    .busy(busy), .grant_id(grant_id), .div_reset(div_reset), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_done(div_done)
  );

  always #10 clk = ~clk;

  // divider stand-in: finishes lat+1 cycles after start, never when hang is set
  always @(posedge clk)
    if (div_reset) begin
      dcnt <= 0;
      div_done <= 1'b0;
    end else if (div_start && !div_done && !hang) begin
      if (dcnt >= lat) begin
        div_done <= 1'b1;
        div_quotient <= div_dividend / div_divisor;
        div_remainder <= div_dividend % div_divisor;
      end
      dcnt <= dcnt + 1;
    end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] m_q(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? 32'hFFFFFFFF : a / b;
  endfunction

  function automatic logic [31:0] m_r(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int rr_pick(input int last, input logic [3:0] p);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (last + k) % 4;
      if (p[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic wait_ack(output int id, output int n, output int sc);
    id = -1;
    n = 0;
    sc = 0;
    while (id < 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (div_start) sc++;
      for (int i = 0; i < 4; i++) if (ack[i]) id = i;
    end
    checks++;
    if (id < 0) begin
      errors++;
      $display("FAIL ack_timeout got=none exp=ack within 400 cycles");
    end else if (!$onehot(ack)) begin
      errors++;
      $display("FAIL ack_onehot got=%b exp=one-hot", ack);
    end
  endtask

  task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic err);
    int g, n, sc;
    @(negedge clk);
    req_dividend[id*32 +: 32] = a;
    req_divisor[id*32 +: 32] = b;
    req = 4'(1) << id;
    wait_ack(g, n, sc);
    if (g < 0) begin
      req = '0;
      return;
    end
    chk("single_id", g, id);
    chk("single_q", res_quotient, q);
    chk("single_r", res_remainder, r);
    chk("single_err", res_err, err);
    if (b == 0) begin
      chk("zero_latency", n, 2);
      chk("zero_no_start", sc, 0);
    end else begin
      chk("start_only_in_run", sc, n - 2);
      chk("start_seen", sc > 0, 1);
    end
    req = '0;
    last_m = id;
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic serve_mask(input logic [3:0] mask);
    int id, n, sc, exp;
    logic [3:0] pend;
    pend = mask;
    order.delete();
    @(negedge clk);
    req = mask;
    while (pend != 0) begin
      exp = rr_pick(last_m, pend);
      wait_ack(id, n, sc);
      if (id < 0) begin
        req = '0;
        return;
      end
      chk("rr_grant", id, exp);
      chk("rr_q", res_quotient, m_q(req_dividend[id*32 +: 32], req_divisor[id*32 +: 32]));
      chk("rr_r", res_remainder, m_r(req_dividend[id*32 +: 32], req_divisor[id*32 +: 32]));
      chk("rr_err", res_err, req_divisor[id*32 +: 32] == 0);
      order.push_back(id);
      req[id[1:0]] = 1'b0;
      pend[id[1:0]] = 1'b0;
      last_m = id;
      @(negedge clk);
      chk("gap_busy", busy, 0);
      chk("gap_ack", ack, 0);
      if (pend != 0) begin
        @(negedge clk);
        chk("regrant_busy", busy, 1);
      end
    end
  endtask

  initial begin
    int seen;
    logic [3:0] mask;
    vecs[0] = '{0, 1000, 7, 142, 6, 0};
    vecs[1] = '{1, 55, 0, 32'hFFFFFFFF, 55, 1};
    vecs[2] = '{2, 900, 100, 9, 0, 0};
    vecs[3] = '{3, 0, 5, 0, 0, 0};
    vecs[4] = '{0, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0};
    vecs[5] = '{1, 7, 9, 0, 7, 0};
    vecs[6] = '{2, 12345, 0, 32'hFFFFFFFF, 12345, 1};
    vecs[7] = '{3, 32'h80000000, 3, 32'h2AAAAAAA, 2, 0};
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_q", res_quotient, 0);
    chk("rst_r", res_remainder, 0);
    chk("rst_err", res_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_div_reset", div_reset, 1);
    chk("rst_div_start", div_start, 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_divisor", div_divisor, 0);
    reset = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      req_dividend[i*32 +: 32] = 100;
      req_divisor[i*32 +: 32] = 3;
    end
    lat = 3;
    serve_mask(4'hF);
    chk("all4_len", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk("all4_order", order[i], i);
    chk("all4_q", res_quotient, 33);
    chk("all4_r", res_remainder, 1);
    for (int i = 0; i < 8; i++) begin
      lat = i;
      single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].err);
    end
    single(2, 20, 4, 5, 0, 0);
    req_dividend[1*32 +: 32] = 81;
    req_divisor[1*32 +: 32] = 9;
    req_dividend[3*32 +: 32] = 50;
    req_divisor[3*32 +: 32] = 7;
    serve_mask(4'b1010);
    chk("fair_len", order.size(), 2);
    if (order.size() == 2) begin
      chk("fair_first", order[0], 3);
      chk("fair_second", order[1], 1);
    end
    @(negedge clk);
    req_dividend[31:0] = 45 * 20;
    req_divisor[31:0] = 100;
    lat = 30;
    req = 4'b0001;
    for (int i = 0; i < 10 && !div_start; i++) @(negedge clk);
    chk("abort_started", div_start, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_div_reset", div_reset, 1);
    chk("abort_div_start", div_start, 0);
    chk("abort_grant", grant_id, 0);
    chk("abort_dividend", div_dividend, 0);
    chk("abort_divisor", div_divisor, 0);
    chk("abort_q", res_quotient, 0);
    chk("abort_err", res_err, 0);
    req = '0;
    @(negedge clk);
    reset = 0;
    last_m = 3;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (|ack) seen = 1;
    end
    chk("abort_no_ack", seen, 0);
    lat = 2;
    single(0, 45 * 20, 100, 9, 0, 0);
    for (int it = 0; it < 25; it++) begin
      lat = $urandom_range(0, 6);
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        req_dividend[i*32 +: 32] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 5000);
        req_divisor[i*32 +: 32] = ($urandom_range(0, 4) == 0) ? 0 :
                                  ($urandom_range(0, 1) ? $urandom_range(1, 50) : $urandom);
      end
      serve_mask(mask);
    end
`ifdef DIVARB_TIMEOUT_EN
    begin
      int id, n, sc;
      hang = 1;
      req_dividend[2*32 +: 32] = 10;
      req_divisor[2*32 +: 32] = 2;
      @(negedge clk);
      req = 4'b0100;
      wait_ack(id, n, sc);
      chk("tmo_id", id, 2);
      chk("tmo_run_cycles", sc, 64);
      chk("tmo_q", res_quotient, 32'hFFFFFFFF);
      chk("tmo_r", res_remainder, 0);
      chk("tmo_err", res_err, 1);
      req = '0;
      hang = 0;
      last_m = 2;
      @(negedge clk);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
